// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU function codes,
// branch opcodes and a branch-decode helper.
package exe_stage_pkg;

    localparam int DATA_W = 8;
    localparam int PC_W   = 12;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDC = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBC = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_MOVB = 4'd7,
        ALU_SHL  = 4'd8,
        ALU_SHR  = 4'd9,
        ALU_ROL  = 4'd10,
        ALU_ROR  = 4'd11
    } alu_op_e;

    localparam logic [4:0] OP_BZ  = 5'b10100;
    localparam logic [4:0] OP_BNZ = 5'b10101;
    localparam logic [4:0] OP_BC  = 5'b10110;
    localparam logic [4:0] OP_BNC = 5'b10111;
    localparam logic [4:0] OP_JMP = 5'b11000;

    // Resolve a branch opcode against the committed C/Z flags.
    function automatic logic branch_cond(input logic [4:0] op, input logic c, input logic z);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_BZ:   taken = z;
            OP_BNZ:  taken = ~z;
            OP_BC:   taken = c;
            OP_BNC:  taken = ~c;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational 8-bit ALU. Function codes 12-15 pass operand A and leave
// the carry untouched; logic ops and MOVB also pass the carry through.
import exe_stage_pkg::*;

module exe_alu (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    input  logic [3:0]        alu_op_i,
    output logic [DATA_W-1:0] res_o,
    output logic              cout_o
);

    logic [DATA_W:0] sum;

    // Function select; subtraction is A + ~B + 1 (or + C), so C=1 means no borrow.
    always_comb begin
        res_o  = a_i;
        cout_o = cin_i;
        sum    = '0;
        case (alu_op_i)
            ALU_ADD: begin
                sum    = {1'b0, a_i} + {1'b0, b_i};
                res_o  = sum[DATA_W-1:0];
                cout_o = sum[DATA_W];
            end
            ALU_ADDC: begin
                sum    = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
                res_o  = sum[DATA_W-1:0];
                cout_o = sum[DATA_W];
            end
            ALU_SUB: begin
                sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};
                res_o  = sum[DATA_W-1:0];
                cout_o = sum[DATA_W];
            end
            ALU_SUBC: begin
                sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, cin_i};
                res_o  = sum[DATA_W-1:0];
                cout_o = sum[DATA_W];
            end
            ALU_AND:  res_o = a_i & b_i;
            ALU_OR:   res_o = a_i | b_i;
            ALU_XOR:  res_o = a_i ^ b_i;
            ALU_MOVB: res_o = b_i;
            ALU_SHL: begin
                res_o  = {a_i[DATA_W-2:0], 1'b0};
                cout_o = a_i[DATA_W-1];
            end
            ALU_SHR: begin
                res_o  = {1'b0, a_i[DATA_W-1:1]};
                cout_o = a_i[0];
            end
            ALU_ROL: begin
                res_o  = {a_i[DATA_W-2:0], a_i[DATA_W-1]};
                cout_o = a_i[DATA_W-1];
            end
            ALU_ROR: begin
                res_o  = {a_i[0], a_i[DATA_W-1:1]};
                cout_o = a_i[0];
            end
            default: begin
                res_o  = a_i;
                cout_o = cin_i;
            end
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand select/forwarding, ALU, committed C/Z flags,
// branch resolution against committed flags, and the EXE/MEM register.
// Optional macro EXE_FWD_EN adds WB ports and operand forwarding.
import exe_stage_pkg::*;

module exe_stage (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_IN,
    input  logic              regWr_IN,
    input  logic              memRd_IN,
    input  logic              memWr_IN,
    input  logic              cWr_IN,
    input  logic              zWr_IN,
    input  logic              immConst_IN,
    input  logic [3:0]        aluOp_IN,
    input  logic [4:0]        opCode_IN,
    input  logic [2:0]        rd_IN,
    input  logic [2:0]        rs_IN,
    input  logic [2:0]        rt_IN,
    input  logic [DATA_W-1:0] regData1_IN,
    input  logic [DATA_W-1:0] regData2_IN,
    input  logic [DATA_W-1:0] brDisp_IN,
    input  logic [PC_W-1:0]   pcPlus1_IN,
`ifdef EXE_FWD_EN
    input  logic              wbRegWr_IN,
    input  logic [2:0]        wbRd_IN,
    input  logic [DATA_W-1:0] wbData_IN,
`endif
    output logic              regWr_OUT,
    output logic              memRd_OUT,
    output logic              memWr_OUT,
    output logic [2:0]        rd_OUT,
    output logic [DATA_W-1:0] aluRes_OUT,
    output logic [DATA_W-1:0] storeData_OUT,
    output logic              brTaken_OUT,
    output logic [PC_W-1:0]   brTarget_OUT,
    output logic              flush_OUT,
    output logic              cFlag_OUT,
    output logic              zFlag_OUT
);

    logic              regWr_q, memRd_q, memWr_q;
    logic [2:0]        rd_q;
    logic [DATA_W-1:0] aluRes_q, storeData_q;
    logic              c_q, z_q;

    logic [DATA_W-1:0] op_a, fwd_b, op_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cout;

`ifdef EXE_FWD_EN
    logic exmem_fwd_ok;
    assign exmem_fwd_ok = regWr_q & ~memRd_q;

    // Forwarding: own EXE/MEM result first (loads are not ready yet), then WB, then register file.
    always_comb begin
        op_a = regData1_IN;
        if (exmem_fwd_ok && (rd_q == rs_IN))
            op_a = aluRes_q;
        else if (wbRegWr_IN && (wbRd_IN == rs_IN))
            op_a = wbData_IN;

        fwd_b = regData2_IN;
        if (exmem_fwd_ok && (rd_q == rt_IN))
            fwd_b = aluRes_q;
        else if (wbRegWr_IN && (wbRd_IN == rt_IN))
            fwd_b = wbData_IN;
    end
`else
    logic unused_reg_addr;
    assign unused_reg_addr = ^{rs_IN, rt_IN};

    // No forwarding: operands come straight from the register file.
    always_comb begin
        op_a  = regData1_IN;
        fwd_b = regData2_IN;
    end
`endif

    assign op_b = immConst_IN ? brDisp_IN : fwd_b;

    exe_alu u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .cin_i    (c_q),
        .alu_op_i (aluOp_IN),
        .res_o    (alu_res),
        .cout_o   (alu_cout)
    );

    // Branches look only at committed flags and are suppressed while stalled.
    always_comb begin
        brTaken_OUT  = branch_cond(opCode_IN, c_q, z_q) & ~stall_IN;
        brTarget_OUT = pcPlus1_IN + {{(PC_W-DATA_W){brDisp_IN[DATA_W-1]}}, brDisp_IN};
    end

    assign flush_OUT = brTaken_OUT;

    // EXE/MEM register and flags: load when not stalled, cleared by async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWr_q     <= 1'b0;
            memRd_q     <= 1'b0;
            memWr_q     <= 1'b0;
            rd_q        <= '0;
            aluRes_q    <= '0;
            storeData_q <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
        end else if (!stall_IN) begin
            regWr_q     <= regWr_IN;
            memRd_q     <= memRd_IN;
            memWr_q     <= memWr_IN;
            rd_q        <= rd_IN;
            aluRes_q    <= alu_res;
            storeData_q <= fwd_b;
            if (cWr_IN) c_q <= alu_cout;
            if (zWr_IN) z_q <= (alu_res == '0);
        end
    end

    assign regWr_OUT     = regWr_q;
    assign memRd_OUT     = memRd_q;
    assign memWr_OUT     = memWr_q;
    assign rd_OUT        = rd_q;
    assign aluRes_OUT    = aluRes_q;
    assign storeData_OUT = storeData_q;
    assign cFlag_OUT     = c_q;
    assign zFlag_OUT     = z_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage. With EXE_FWD_EN defined it also connects
// the WB ports and exercises forwarding.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_IN, regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN, immConst_IN;
    logic [3:0]  aluOp_IN;
    logic [4:0]  opCode_IN;
    logic [2:0]  rd_IN, rs_IN, rt_IN;
    logic [7:0]  regData1_IN, regData2_IN, brDisp_IN;
    logic [11:0] pcPlus1_IN;
`ifdef EXE_FWD_EN
    logic        wbRegWr_IN;
    logic [2:0]  wbRd_IN;
    logic [7:0]  wbData_IN;
`endif
    logic        regWr_OUT, memRd_OUT, memWr_OUT;
    logic [2:0]  rd_OUT;
    logic [7:0]  aluRes_OUT, storeData_OUT;
    logic        brTaken_OUT, flush_OUT, cFlag_OUT, zFlag_OUT;
    logic [11:0] brTarget_OUT;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_IN      (stall_IN),
        .regWr_IN      (regWr_IN),
        .memRd_IN      (memRd_IN),
        .memWr_IN      (memWr_IN),
        .cWr_IN        (cWr_IN),
        .zWr_IN        (zWr_IN),
        .immConst_IN   (immConst_IN),
        .aluOp_IN      (aluOp_IN),
        .opCode_IN     (opCode_IN),
        .rd_IN         (rd_IN),
        .rs_IN         (rs_IN),
        .rt_IN         (rt_IN),
        .regData1_IN   (regData1_IN),
        .regData2_IN   (regData2_IN),
        .brDisp_IN     (brDisp_IN),
        .pcPlus1_IN    (pcPlus1_IN),
`ifdef EXE_FWD_EN
        .wbRegWr_IN    (wbRegWr_IN),
        .wbRd_IN       (wbRd_IN),
        .wbData_IN     (wbData_IN),
`endif
        .regWr_OUT     (regWr_OUT),
        .memRd_OUT     (memRd_OUT),
        .memWr_OUT     (memWr_OUT),
        .rd_OUT        (rd_OUT),
        .aluRes_OUT    (aluRes_OUT),
        .storeData_OUT (storeData_OUT),
        .brTaken_OUT   (brTaken_OUT),
        .brTarget_OUT  (brTarget_OUT),
        .flush_OUT     (flush_OUT),
        .cFlag_OUT     (cFlag_OUT),
        .zFlag_OUT     (zFlag_OUT)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic cwr, input logic zwr);
        aluOp_IN    = op;
        regData1_IN = a;
        regData2_IN = b;
        cWr_IN      = cwr;
        zWr_IN      = zwr;
        immConst_IN = 1'b0;
        opCode_IN   = 5'd0;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       chk_c;
        logic       z;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // carry chain starts at C=0 (left by the stall test)
        vecs[0]  = '{4'd1,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{4'd1,  8'h10, 8'h20, 8'h31, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'd3,  8'h10, 8'h05, 8'h0A, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{4'd2,  8'h05, 8'h10, 8'hF5, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'd3,  8'h05, 8'h04, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{4'd4,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'd5,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'd6,  8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{4'd7,  8'h12, 8'h34, 8'h34, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'd8,  8'h81, 8'h00, 8'h02, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{4'd9,  8'h02, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'd10, 8'h81, 8'h00, 8'h03, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{4'd11, 8'h02, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{4'd12, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{4'd11, 8'h01, 8'h00, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{4'd15, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        stall_IN = 0; regWr_IN = 0; memRd_IN = 0; memWr_IN = 0;
        cWr_IN = 0; zWr_IN = 0; immConst_IN = 0;
        aluOp_IN = 0; opCode_IN = 0; rd_IN = 0; rs_IN = 0; rt_IN = 0;
        regData1_IN = 0; regData2_IN = 0; brDisp_IN = 0; pcPlus1_IN = 0;
`ifdef EXE_FWD_EN
        wbRegWr_IN = 0; wbRd_IN = 0; wbData_IN = 0;
`endif
        #12;
        check("rst_alu",   {8'h0, aluRes_OUT}, 16'h0);
        check("rst_flags", {14'h0, cFlag_OUT, zFlag_OUT}, 16'h0);
        check("rst_ctl",   {13'h0, regWr_OUT, memRd_OUT, memWr_OUT}, 16'h0);
        rst = 1'b0;

        // ADD F0+20 -> 10, carry out
        set_alu(4'd0, 8'hF0, 8'h20, 1'b1, 1'b1);
        regWr_IN = 1; rd_IN = 3'd3;
        step();
        check("add_res",   {8'h0, aluRes_OUT}, 16'h0010);
        check("add_c",     {15'h0, cFlag_OUT}, 16'h1);
        check("add_z",     {15'h0, zFlag_OUT}, 16'h0);
        check("add_rd",    {13'h0, rd_OUT}, 16'h3);
        check("add_regwr", {15'h0, regWr_OUT}, 16'h1);

        // SUB 05 - imm 05 -> 0, store data is regData2 not the immediate
        set_alu(4'd2, 8'h05, 8'hAA, 1'b1, 1'b1);
        immConst_IN = 1; brDisp_IN = 8'h05; rd_IN = 3'd2; memWr_IN = 1;
        step();
        check("sub_res",   {8'h0, aluRes_OUT}, 16'h0000);
        check("sub_z",     {15'h0, zFlag_OUT}, 16'h1);
        check("sub_c",     {15'h0, cFlag_OUT}, 16'h1);
        check("sub_store", {8'h0, storeData_OUT}, 16'h00AA);
        check("sub_memwr", {15'h0, memWr_OUT}, 16'h1);

        // Branch resolution against committed flags (C=1, Z=1), no clocking
        set_alu(4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        regWr_IN = 0; memWr_IN = 0;
        pcPlus1_IN = 12'h010; brDisp_IN = 8'hFE;
        opCode_IN = 5'b10100; #1;
        check("bz_taken",  {15'h0, brTaken_OUT}, 16'h1);
        check("bz_target", {4'h0, brTarget_OUT}, 16'h000E);
        check("bz_flush",  {15'h0, flush_OUT}, 16'h1);
        opCode_IN = 5'b10101; #1;
        check("bnz_taken", {15'h0, brTaken_OUT}, 16'h0);
        opCode_IN = 5'b10110; #1;
        check("bc_taken",  {15'h0, brTaken_OUT}, 16'h1);
        opCode_IN = 5'b10111; #1;
        check("bnc_taken", {15'h0, brTaken_OUT}, 16'h0);
        opCode_IN = 5'b00000; #1;
        check("nonbr",     {14'h0, brTaken_OUT, flush_OUT}, 16'h0);
        opCode_IN = 5'b11000; pcPlus1_IN = 12'hFFF; brDisp_IN = 8'h02; #1;
        check("jmp_taken", {15'h0, brTaken_OUT}, 16'h1);
        check("jmp_wrap",  {4'h0, brTarget_OUT}, 16'h0001);

        // Stall three edges during ADD 01+02 with a JMP opcode present
        set_alu(4'd0, 8'h01, 8'h02, 1'b1, 1'b1);
        opCode_IN = 5'b11000; regWr_IN = 1; rd_IN = 3'd5;
        stall_IN = 1; #1;
        check("stall_br0", {15'h0, brTaken_OUT}, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_res",   {8'h0, aluRes_OUT}, 16'h0000);
            check("stall_flags", {14'h0, cFlag_OUT, zFlag_OUT}, 16'h3);
            check("stall_br",    {15'h0, brTaken_OUT}, 16'h0);
        end
        stall_IN = 0; #1;
        check("unstall_br", {15'h0, brTaken_OUT}, 16'h1);
        step();
        check("unstall_res",   {8'h0, aluRes_OUT}, 16'h0003);
        check("unstall_flags", {14'h0, cFlag_OUT, zFlag_OUT}, 16'h0);
        check("unstall_rd",    {13'h0, rd_OUT}, 16'h5);

        // ALU function table, C/Z written every time
        regWr_IN = 0;
        for (int i = 0; i < 16; i++) begin
            set_alu(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 1'b1);
            step();
            check($sformatf("alu%0d_res", i), {8'h0, aluRes_OUT}, {8'h0, vecs[i].res});
            check($sformatf("alu%0d_z", i), {15'h0, zFlag_OUT}, {15'h0, vecs[i].z});
            if (vecs[i].chk_c)
                check($sformatf("alu%0d_c", i), {15'h0, cFlag_OUT}, {15'h0, vecs[i].c});
        end

        // Flags hold when not written (C=1, Z=1 from last vector)
        set_alu(4'd0, 8'h01, 8'h01, 1'b0, 1'b0);
        step();
        check("nowr_res",   {8'h0, aluRes_OUT}, 16'h0002);
        check("nowr_flags", {14'h0, cFlag_OUT, zFlag_OUT}, 16'h3);

        // Async reset between edges, then resume
        set_alu(4'd0, 8'hFF, 8'h02, 1'b1, 1'b1);
        regWr_IN = 1; memRd_IN = 1; rd_IN = 3'd4;
        step();
        check("pre_rst_res", {8'h0, aluRes_OUT}, 16'h0001);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_res",   {8'h0, aluRes_OUT}, 16'h0);
        check("mid_rst_flags", {14'h0, cFlag_OUT, zFlag_OUT}, 16'h0);
        check("mid_rst_ctl",   {10'h0, regWr_OUT, memRd_OUT, memWr_OUT, rd_OUT}, 16'h0);
        #1 rst = 1'b0;
        step();
        check("post_rst_res", {8'h0, aluRes_OUT}, 16'h0001);
        check("post_rst_c",   {15'h0, cFlag_OUT}, 16'h1);
        check("post_rst_ctl", {12'h0, regWr_OUT, memRd_OUT, rd_OUT[1:0]}, 16'h000C);

`ifdef EXE_FWD_EN
        // ADD r1 = 33, then read r1 with stale file data and WB also writing r1
        set_alu(4'd0, 8'h30, 8'h03, 1'b0, 1'b0);
        regWr_IN = 1; memRd_IN = 0; rd_IN = 3'd1;
        step();
        check("fwd_prod", {8'h0, aluRes_OUT}, 16'h0033);
        set_alu(4'd12, 8'h00, 8'h00, 1'b0, 1'b0);
        regWr_IN = 0; rs_IN = 3'd1; rt_IN = 3'd1;
        wbRegWr_IN = 1; wbRd_IN = 3'd1; wbData_IN = 8'h77;
        step();
        check("fwd_exmem_a", {8'h0, aluRes_OUT}, 16'h0033);
        check("fwd_exmem_b", {8'h0, storeData_OUT}, 16'h0033);
        step();
        check("fwd_wb_a", {8'h0, aluRes_OUT}, 16'h0077);
        check("fwd_wb_b", {8'h0, storeData_OUT}, 16'h0077);
        wbRegWr_IN = 0; regData1_IN = 8'h5A; regData2_IN = 8'hC3;
        step();
        check("fwd_none_a", {8'h0, aluRes_OUT}, 16'h005A);
        check("fwd_none_b", {8'h0, storeData_OUT}, 16'h00C3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The block SHALL use clk, input, 1: rising-edge clock for all state.
REQ-002 The block SHALL use rst, input, 1: reset, asynchronous, active-high.
REQ-003 The block SHALL have stall_IN, input, 1: when high, hold flags and EXE/MEM outputs.
REQ-004 The block SHALL have regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN, immConst_IN, input, 1 each: ID/EXE control bits.
REQ-005 The block SHALL have aluOp_IN, input, 4, and opCode_IN, input, 5: ALU function and instruction opcode.
REQ-006 The block SHALL have rd_IN, rs_IN, rt_IN, input, 3 each: register addresses.
REQ-007 The block SHALL have regData1_IN, regData2_IN, brDisp_IN, input, 8 each: operand A, operand B, immediate/displacement.
REQ-008 The block SHALL have pcPlus1_IN, input, 12: PC of the instruction plus one.
REQ-009 The block SHALL have regWr_OUT, memRd_OUT, memWr_OUT, output, 1 each: registered EXE/MEM control.
REQ-010 The block SHALL have rd_OUT, output, 3; aluRes_OUT, output, 8; storeData_OUT, output, 8: registered EXE/MEM data.
REQ-011 The block SHALL have brTaken_OUT, output, 1, and brTarget_OUT, output, 12: combinational redirect to IF.
REQ-012 The block SHALL have flush_OUT, output, 1: equal to brTaken_OUT, clears IF/ID and ID/EXE.
REQ-013 The block SHALL have cFlag_OUT, zFlag_OUT, output, 1 each: committed flag registers.

Function
REQ-014 Operand B SHALL be brDisp_IN when immConst_IN=1, else regData2_IN (after forwarding).
REQ-015 aluOp SHALL map: 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 AND, 5 OR, 6 XOR, 7 MOVB, 8 SHL, 9 SHR, 10 ROL, 11 ROR; 12-15 pass A, C unchanged.
REQ-016 ADD/ADDC SHALL compute 9-bit A+B(+C) with carry = bit 8; SUB/SUBC SHALL compute A+~B+1 (A+~B+C for SUBC), C=1 meaning no borrow.
REQ-017 SHL/SHR SHALL shift by one, C receiving the bit shifted out; ROL/ROR SHALL rotate through nothing, C receiving the bit moved.
REQ-018 On a rising edge with stall_IN=0, C SHALL load the new carry if cWr_IN=1 and Z SHALL load (result==0) if zWr_IN=1; otherwise both hold.
REQ-019 Branches SHALL evaluate the committed flag registers (not the current ALU result): BZ taken if Z=1, BNZ if Z=0, BC if C=1, BNC if C=0, JMP always.
REQ-020 brTarget_OUT SHALL be pcPlus1_IN + sign-extended brDisp_IN, modulo 2^12 (wrap-around, no overflow flag).
REQ-021 brTaken_OUT SHALL be 0 for non-branch opcodes and while stall_IN=1.
REQ-022 EXE/MEM outputs SHALL register one cycle after inputs (latency 1) with storeData_OUT = forwarded regData2, not the immediate.
REQ-023 With stall_IN=1, all registered outputs and flags SHALL hold; stall and branch on the same cycle SHALL produce no redirect until stall drops.

Reset
REQ-024 rst=1 SHALL asynchronously clear all registered outputs, C and Z to 0, independent of clk and stall_IN.
REQ-025 Reset asserted mid-instruction SHALL discard it; the first edge after deassertion SHALL capture inputs normally.

Configuration
REQ-026 With macro EXE_FWD_EN defined, ports wbRegWr_IN (1), wbRd_IN (3), wbData_IN (8) SHALL exist and forwarding SHALL be active.
REQ-027 Forwarding priority per operand: own EXE/MEM register (regWr_OUT=1, memRd_OUT=0, rd_OUT match), then WB (wbRegWr_IN=1, wbRd_IN match), then register-file data.
REQ-028 Without EXE_FWD_EN, the wb ports SHALL be absent and operands SHALL be regData1_IN/regData2_IN unmodified.

Structure
REQ-029 A shared package SHALL hold the aluOp codes, branch opcode constants (BZ 5'b10100, BNZ 5'b10101, BC 5'b10110, BNC 5'b10111, JMP 5'b11000) and data/PC widths 8/12.
REQ-030 The combinational ALU SHALL be a sub-module named exe_alu (A, B, Cin, aluOp -> result, Cout); flags, branch logic and the output register remain in exe_stage.

Verification
REQ-031 ADD A=8'hF0, B=8'h20, cWr=zWr=1 -> next edge aluRes_OUT=8'h10, C=1, Z=0.
REQ-032 SUB A=8'h05, immConst=1, brDisp=8'h05, zWr=1 -> aluRes_OUT=8'h00, Z=1; following BZ with pcPlus1=12'h010, brDisp=8'hFE -> brTaken=1, brTarget=12'h00E, flush=1.
REQ-033 JMP with pcPlus1=12'hFFF, brDisp=8'h02 -> brTarget=12'h001 (wrap).
REQ-034 stall_IN=1 for 3 cycles during ADD with cWr=1 -> outputs and C unchanged, brTaken=0; update occurs on the first unstalled edge.
REQ-035 (EXE_FWD_EN) ADD r1 writes 8'h33, next instruction rs=r1 with stale regData1=8'h00 and WB also writing r1=8'h77 -> operand A=8'h33.
REQ-036 rst pulsed between clock edges during a stream -> all outputs, C, Z read 0 immediately; resumes on next edge.
